// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Function : Registered RV32I-class decode stage with valid/ready handshake,
//            flush, one-bubble load-use interlock and illegal-opcode flag.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [31:0]         instr_i,
    output logic [REG_AW-1:0]   rs1_addr_o,
    output logic [REG_AW-1:0]   rs2_addr_o,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic                flush_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     pc_o,
    output logic [XLEN-1:0]     rs1_data_o,
    output logic [XLEN-1:0]     rs2_data_o,
    output logic [REG_AW-1:0]   rd_addr_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [3:0]          funct_o,
    output logic [6:0]          opcode_o,
    output logic                branch,
    output logic                memread,
    output logic                memtoreg,
    output logic                memwrite,
    output logic                alusrc,
    output logic                regwrite,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                illegal_o
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    logic [6:0]         w_opcode;
    logic [4:0]         w_rd;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic               w_use_rs1;
    logic               w_use_rs2;
    logic               w_has_rd;
    logic               w_illegal;
    logic [5:0]         w_ctl;      // {branch, memread, memtoreg, memwrite, alusrc, regwrite}
    logic [1:0]         w_aluop;
    logic signed [31:0] w_imm32;
    logic [REG_AW-1:0]  w_rd_dec;
    logic               w_hz;
    logic               w_adv;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_rs1    = instr_i[19:15];
    assign w_rs2    = instr_i[24:20];

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_has_rd  = 1'b0;
        w_illegal = 1'b0;
        w_ctl     = 6'b000000;
        w_aluop   = 2'b00;
        w_imm32   = '0;
        case (w_opcode)
            c_OP_R: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_has_rd = 1'b1;
                w_ctl = 6'b000001; w_aluop = 2'b10;
            end
            c_OP_I: begin
                w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_ctl = 6'b000011; w_aluop = 2'b10;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            c_OP_LOAD: begin
                w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_ctl = 6'b011011; w_aluop = 2'b00;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            c_OP_STORE: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_ctl = 6'b000110; w_aluop = 2'b00;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            c_OP_BRANCH: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_ctl = 6'b100000; w_aluop = 2'b01;
                w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            c_OP_JAL: begin
                w_has_rd = 1'b1;
                w_ctl = 6'b100001; w_aluop = 2'b11;
                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            c_OP_JALR: begin
                w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_ctl = 6'b100001; w_aluop = 2'b11;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_has_rd = 1'b1;
                w_ctl = 6'b000001; w_aluop = 2'b11;
                w_imm32 = {instr_i[31:12], 12'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Unused sources read x0 so the regfile port never aliases a live register.
    assign rs1_addr_o = w_use_rs1 ? REG_AW'(w_rs1) : '0;
    assign rs2_addr_o = w_use_rs2 ? REG_AW'(w_rs2) : '0;
    assign w_rd_dec   = w_has_rd  ? REG_AW'(w_rd)  : '0;

    assign w_hz = out_valid & memread & (rd_addr_o != '0) & in_valid &
                  ((w_use_rs1 & (rs1_addr_o == rd_addr_o)) |
                   (w_use_rs2 & (rs2_addr_o == rd_addr_o)));

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = flush_i | (w_adv & ~w_hz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            pc_o       <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            rd_addr_o  <= '0;
            imm_o      <= '0;
            funct_o    <= '0;
            opcode_o   <= '0;
            branch     <= 1'b0;
            memread    <= 1'b0;
            memtoreg   <= 1'b0;
            memwrite   <= 1'b0;
            alusrc     <= 1'b0;
            regwrite   <= 1'b0;
            aluop      <= '0;
            illegal_o  <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
        end else if (w_adv && w_hz) begin
            out_valid <= 1'b0;
        end else if (w_adv && in_valid) begin
            out_valid  <= 1'b1;
            pc_o       <= pc_i;
            rs1_data_o <= w_use_rs1 ? rs1_data_i : '0;
            rs2_data_o <= w_use_rs2 ? rs2_data_i : '0;
            rd_addr_o  <= w_rd_dec;
            imm_o      <= XLEN'(w_imm32);
            funct_o    <= {instr_i[30], instr_i[14:12]};
            opcode_o   <= w_opcode;
            {branch, memread, memtoreg, memwrite, alusrc, regwrite} <= w_ctl;
            aluop      <= ALUOP_W'(w_aluop);
            illegal_o  <= w_illegal;
        end else if (w_adv) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Function : Directed plus random checks of id_stage_pipe against a
//            cycle-level reference model of decode and handshake rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush_i, out_valid, out_ready;
    logic [31:0] pc_i, instr_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [3:0]  funct_o;
    logic [6:0]  opcode_o;
    logic        branch, memread, memtoreg, memwrite, alusrc, regwrite, illegal_o;
    logic [1:0]  aluop;

    logic [31:0] regs [32];
    int          total = 0;
    int          bad   = 0;
    logic        ir_seen;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  funct;
        logic [6:0]  opc;
        logic [5:0]  ctl;
        logic [1:0]  aluop;
        logic        ill;
    } bundle_t;

    bundle_t m;

    always #5 clk = ~clk;

    assign rs1_data_i = regs[rs1_addr_o];
    assign rs2_data_i = regs[rs2_addr_o];

    id_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .instr_i(instr_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .rd_addr_o(rd_addr_o),
        .imm_o(imm_o), .funct_o(funct_o), .opcode_o(opcode_o), .branch(branch),
        .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc),
        .regwrite(regwrite), .aluop(aluop), .illegal_o(illegal_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Immediates built arithmetically: signed weight of bit 31 plus positive fields.
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                           output logic u1, output logic u2);
        bundle_t b;
        logic    hr;
        int      v;
        b = '0; u1 = 1'b0; u2 = 1'b0; hr = 1'b0; v = 0;
        b.valid = 1'b1;
        b.pc    = pcv;
        b.funct = {ins[30], ins[14:12]};
        b.opc   = ins[6:0];
        case (ins[6:0])
            7'h33: begin u1 = 1; u2 = 1; hr = 1; b.ctl = 6'b000001; b.aluop = 2'd2; end
            7'h13: begin u1 = 1; hr = 1; b.ctl = 6'b000011; b.aluop = 2'd2;
                         v = int'(ins[31:20]) - (ins[31] ? 4096 : 0); end
            7'h03: begin u1 = 1; hr = 1; b.ctl = 6'b011011; b.aluop = 2'd0;
                         v = int'(ins[31:20]) - (ins[31] ? 4096 : 0); end
            7'h23: begin u1 = 1; u2 = 1; b.ctl = 6'b000110; b.aluop = 2'd0;
                         v = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0); end
            7'h63: begin u1 = 1; u2 = 1; b.ctl = 6'b100000; b.aluop = 2'd1;
                         v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                             - (ins[31] ? 4096 : 0); end
            7'h6F: begin hr = 1; b.ctl = 6'b100001; b.aluop = 2'd3;
                         v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                             - (ins[31] ? 1048576 : 0); end
            7'h67: begin u1 = 1; hr = 1; b.ctl = 6'b100001; b.aluop = 2'd3;
                         v = int'(ins[31:20]) - (ins[31] ? 4096 : 0); end
            7'h37, 7'h17: begin hr = 1; b.ctl = 6'b000001; b.aluop = 2'd3;
                         v = int'(ins[31:12]) * 4096; end
            default: b.ill = 1'b1;
        endcase
        b.imm = 32'(v);
        b.rd  = hr ? ins[11:7] : 5'd0;
        b.d1  = u1 ? regs[ins[19:15]] : 32'd0;
        b.d2  = u2 ? regs[ins[24:20]] : 32'd0;
        return b;
    endfunction

    task automatic check_bundle(input string pfx);
        chk({pfx, ".valid"}, 32'(out_valid), 32'(m.valid));
        chk({pfx, ".pc"},    pc_o,           m.pc);
        chk({pfx, ".d1"},    rs1_data_o,     m.d1);
        chk({pfx, ".d2"},    rs2_data_o,     m.d2);
        chk({pfx, ".rd"},    32'(rd_addr_o), 32'(m.rd));
        chk({pfx, ".imm"},   imm_o,          m.imm);
        chk({pfx, ".funct"}, 32'(funct_o),   32'(m.funct));
        chk({pfx, ".opc"},   32'(opcode_o),  32'(m.opc));
        chk({pfx, ".ctl"},   32'({branch, memread, memtoreg, memwrite, alusrc, regwrite}), 32'(m.ctl));
        chk({pfx, ".aluop"}, 32'(aluop),     32'(m.aluop));
        chk({pfx, ".ill"},   32'(illegal_o), 32'(m.ill));
    endtask

    // One clock: check in_ready, predict next bundle, advance, compare.
    task automatic step(input string pfx);
        bundle_t d, n;
        logic    u1, u2, adv, hz, ir;
        #1;
        d   = ref_decode(instr_i, pc_i, u1, u2);
        adv = !m.valid || out_ready;
        hz  = m.valid && m.ctl[4] && (m.rd != 5'd0) && in_valid &&
              ((u1 && instr_i[19:15] == m.rd) || (u2 && instr_i[24:20] == m.rd));
        ir  = flush_i || (adv && !hz);
        ir_seen = in_ready;
        chk({pfx, ".in_ready"}, 32'(in_ready), 32'(ir));
        n = m;
        if (flush_i)                n.valid = 1'b0;
        else if (adv && hz)         n.valid = 1'b0;
        else if (adv && in_valid)   n = d;
        else if (adv)               n.valid = 1'b0;
        @(posedge clk);
        #1;
        m = n;
        check_bundle(pfx);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 10))
            0: ins[6:0] = 7'h33;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h03;  4: ins[6:0] = 7'h23;  5: ins[6:0] = 7'h63;
            6: ins[6:0] = 7'h6F;  7: ins[6:0] = 7'h67;  8: ins[6:0] = 7'h37;
            9: ins[6:0] = 7'h17;  default: ins[6:0] = 7'h7F;
        endcase
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        rst_n = 1'b0; in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
        pc_i = 32'h0; instr_i = 32'h0;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_bundle("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        in_valid = 1'b1; pc_i = 32'h100; instr_i = 32'h002081B3;
        step("add");
        chk("add.valid", 32'(out_valid), 32'd1);
        chk("add.rd", 32'(rd_addr_o), 32'd3);
        chk("add.rs1", rs1_data_o, 32'd5);
        chk("add.rs2", rs2_data_o, 32'd7);
        chk("add.ctl", 32'({regwrite, aluop, funct_o}), 32'b1_10_0000);

        pc_i = 32'h104; instr_i = 32'h0080A283;
        step("lw");
        chk("lw.imm", imm_o, 32'd8);
        chk("lw.mem", 32'({memread, memtoreg}), 32'b11);

        pc_i = 32'h108; instr_i = 32'h00528333;
        step("lu_stall");
        chk("lu.in_ready_low", 32'(ir_seen), 32'd0);
        chk("lu.bubble", 32'(out_valid), 32'd0);
        step("lu_go");
        chk("lu.in_ready_high", 32'(ir_seen), 32'd1);
        chk("lu.add_rd", 32'(rd_addr_o), 32'd6);

        out_ready = 1'b0; pc_i = 32'h10C; instr_i = 32'h0020A623;
        for (int k = 0; k < 3; k++) begin
            step("bp_hold");
            chk("bp.in_ready", 32'(ir_seen), 32'd0);
            chk("bp.rd", 32'(rd_addr_o), 32'd6);
            chk("bp.pc", pc_o, 32'h108);
        end
        out_ready = 1'b1;
        step("sw");
        chk("sw.rd", 32'(rd_addr_o), 32'd0);
        chk("sw.memwrite", 32'(memwrite), 32'd1);
        chk("sw.imm", imm_o, 32'd12);

        out_ready = 1'b0; flush_i = 1'b1; pc_i = 32'h110; instr_i = 32'hFFDFF0EF;
        step("flush");
        chk("flush.in_ready", 32'(ir_seen), 32'd1);
        chk("flush.valid", 32'(out_valid), 32'd0);
        flush_i = 1'b0; out_ready = 1'b1;

        step("jal");
        chk("jal.imm", imm_o, 32'hFFFFFFFC);
        chk("jal.br_aluop", 32'({branch, aluop}), 32'b1_11);

        pc_i = 32'h114; instr_i = 32'h0000007F;
        step("illegal");
        chk("illegal.flag", 32'(illegal_o), 32'd1);
        chk("illegal.ctl", 32'({branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop}), 32'd0);

        pc_i = 32'h118; instr_i = 32'h0000A003;
        step("lw_x0");
        pc_i = 32'h11C; instr_i = 32'h00000333;
        step("rd0_nohz");
        chk("rd0.in_ready", 32'(ir_seen), 32'd1);
        chk("rd0.valid", 32'(out_valid), 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.pc", pc_o, 32'd0);
        m = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush_i   = ($urandom_range(0, 12) == 0);
            pc_i      = $urandom;
            instr_i   = rand_instr();
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = $urandom;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, pipelined instruction-decode stage that sits between the fetch register and the execute stage. It decodes RV32I-class instructions into the team's branch/memread/memtoreg/memwrite/alusrc/regwrite/aluop control set, immediate and funct. Unlike the combinational decoder, it registers all outputs behind a valid/ready handshake. It adds pipeline flush, a one-bubble load-use interlock and illegal-opcode flagging.

## Interface
- XLEN, 32, datapath and PC width
- REG_AW, 5, register address width
- ALUOP_W, 2, aluop width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  fetch presents pc_i/instr_i
- in_ready  out  1  stage accepts this cycle
- pc_i  in  XLEN  instruction PC
- instr_i  in  32  instruction word
- rs1_addr_o, rs2_addr_o  out  REG_AW each  combinational register-file read addresses
- rs1_data_i, rs2_data_i  in  XLEN each  same-cycle read data; the regfile forwards write-first
- flush_i  in  1  kill stage contents (taken branch/jump)
- out_valid  out  1  registered bundle valid
- out_ready  in  1  execute accepts bundle
- Registered bundle outputs:
  - pc_o  XLEN
  - rs1_data_o, rs2_data_o  XLEN each
  - rd_addr_o  REG_AW
  - imm_o  XLEN
  - funct_o  4
  - opcode_o  7
  - branch, memread, memtoreg, memwrite, alusrc, regwrite  1 each
  - aluop  ALUOP_W
  - illegal_o  1

## Operation
- **Field extraction:**
  - opcode = instr[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20].
  - funct = {instr[30], funct3}.
- **Decode per opcode.** Controls are listed as br/mr/m2r/mw/src/rw/aluop.
  - R 0110011: rs1+rs2 used, rd=rd, 0/0/0/0/0/1/10, imm=0.
  - I 0010011: rs1 used, rd=rd, 0/0/0/0/1/1/10, imm=sext(instr[31:20]).
  - IL 0000011: rs1 used, rd=rd, 0/1/1/0/1/1/00, imm=sext(instr[31:20]).
  - S 0100011: rs1+rs2 used, rd=0, 0/0/0/1/1/0/00, imm=sext({instr[31:25],instr[11:7]}).
  - B 1100011: rs1+rs2 used, rd=0, 1/0/0/0/0/0/01, imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - J 1101111: no sources, rd=rd, 1/0/0/0/0/1/11, imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - JR 1100111: rs1 used, rd=rd, 1/0/0/0/0/1/11, imm=sext(instr[31:20]).
  - U 0110111 and UPC 0010111: no sources, rd=rd, 0/0/0/0/0/1/11, imm={instr[31:12],12'b0}.
  - Any other opcode: illegal=1, all controls 0, rd=0, imm=0.
- Unused source addresses drive 0, and the matching *_data_o is 0.
- Sign extension is to XLEN from bit 31 of the instruction. pc_o is XLEN wide.
- **Load-use hazard (comb.):**
  - hz = out_valid & memread & (rd_addr_o≠0) & in_valid & ((rs1 used & rs1==rd_addr_o) | (rs2 used & rs2==rd_addr_o)).
- **Handshake:**
  - adv = ~out_valid | out_ready.
  - in_ready = flush_i | (adv & ~hz).
- **Register update at clk, in priority order:**
  - flush_i: out_valid←0. Any accepted input is discarded.
  - else if adv & hz: out_valid←0, a bubble. The input is held upstream.
  - else if adv & in_valid: the bundle loads decoded input and out_valid←1.
  - else if adv: out_valid←0.
  - else: hold all outputs unchanged.
- While out_valid=1 & out_ready=0, every bundle output is stable.

## Timing
- Reset: every registered output is 0, including out_valid. in_ready = 1 after reset because out_valid=0.
- Reset asserted mid-operation clears the bundle immediately, asynchronously.
- Latency: one cycle from the accepting edge to out_valid. Throughput is one instruction per cycle with no hazard.
- Load-use costs exactly one bubble cycle. The dependent instruction is accepted the cycle after the load leaves.
- Register data is sampled at the accept edge only. A stall does not re-read it.
- flush_i coincident with a hazard or with backpressure: the flush wins, and out_valid=0 next cycle.
- rd=0 loads never trigger hz.

## Test plan
- **Reset then R-type.** Pulse rst_n low, then present 0x002081B3 (add x3,x1,x2) with x1=5, x2=7. Next cycle: out_valid=1, rd=3, rs1_data=5, rs2_data=7, regwrite=1, aluop=10, funct=0000.
- **Load-use.** Send 0x0080A283 (lw x5,8(x1)), then 0x00528333 (add x6,x5,x5), with out_ready=1.
  - Load appears with imm=8, memread=memtoreg=1.
  - Next cycle: out_valid=0 and in_ready was 0.
  - The cycle after: the add appears.
- **Backpressure.** Hold out_ready=0 for 3 cycles with the add valid. Required: the bundle is unchanged, in_ready=0, no instruction is lost. After release the next instruction follows in one cycle.
- **Flush.** Assert flush_i with a valid bundle and a valid input. Next cycle out_valid=0, and the input is discarded (in_ready=1).
- **Jump, store and illegal decode.**
  - jal x1,-4 (0xFFDFF0EF): imm=0xFFFFFFFC, branch=1, aluop=11.
  - sw x2,12(x1) (0x0020A623): rd=0, memwrite=1, imm=12.
  - Word 0x0000007F: illegal_o=1, all controls 0.
